display_scan_mux: RTL and testbench
===================================

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 Parameter CLK_DIV, default 50000: clock cycles each digit stays selected; legal range 4..2^20.
REQ-002 Parameter GUARD, default 2: cycles at the start of each digit slot with all anodes off (anti-ghosting); legal range 1..CLK_DIV-2.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 value  input  16  four hex digits to display; digit i = value[4i+3:4i], digit 0 rightmost.
REQ-006 load  input  1  one-cycle strobe; capture value into the holding register.
REQ-007 blank_lz  input  1  1 = blank leading zero digits.
REQ-008 digit  output  4  nibble for the downstream 7-segment decoder D input.
REQ-009 an  output  4  active-low one-hot anode enables, common-anode display; an[i] low lights digit i.
REQ-010 slot_tick  output  1  one-cycle pulse on the cycle idx advances.

Function
REQ-011 State: value_reg[15:0], cnt (0..CLK_DIV-1), idx[1:0].
REQ-012 cnt increments every cycle and wraps from CLK_DIV-1 to 0.
REQ-013 On the cycle cnt wraps, idx advances 0->1->2->3->0 (wrap 3->0) and slot_tick = 1; otherwise slot_tick = 0.
REQ-014 load = 1 writes value into value_reg on that edge.
REQ-015 load never disturbs cnt or idx.
REQ-016 The new value_reg content appears on digit/an from the next edge.
REQ-017 Back-to-back loads: last one wins.
REQ-018 digit, an and slot_tick are flip-flop outputs.
REQ-019 All three update on the same edge as the state, from next-state values: no combinational path from inputs to outputs.
REQ-020 digit = value_reg nibble selected by idx; digit holds even when the digit is blanked.
REQ-021 Digit i (i>0) is blanked when blank_lz = 1 and nibbles i..3 of value_reg are all zero.
REQ-022 Digit 0 is never blanked.
REQ-023 an = 4'b1111 when cnt < GUARD or the current digit is blanked.
REQ-024 Otherwise an = ~(4'b0001 << idx).
REQ-025 At most one an bit is low in any cycle.
REQ-026 blank_lz changes take effect on the next edge, with no other side effects.

Reset
REQ-027 rst = 1 immediately, independent of clk, forces:
- value_reg = 0, cnt = 0, idx = 0
- digit = 4'h0, an = 4'b1111, slot_tick = 0
REQ-028 load during reset is ignored.
REQ-029 Reset asserted mid-slot aborts the slot; no partial state is retained.
REQ-030 After rst falls, the first edge sets cnt = 1, idx = 0.
REQ-031 With GUARD = 1, that first edge also drives an = 4'b1110 and digit = 0.

Verification
Parameters for all scenarios: CLK_DIV = 4, GUARD = 1.
REQ-032 Reset: assert rst asynchronously mid-slot -> same cycle an = 4'b1111, digit = 0, slot_tick = 0; all hold while rst = 1.
REQ-033 Scan order: load 16'h12AB, blank_lz = 0 -> digit sequence B,A,2,1 repeating.
- each digit held 4 cycles
- an per slot: 1111 for 1 cycle, then 1110 / 1101 / 1011 / 0111 for 3 cycles
- slot_tick pulses once per 4 cycles
REQ-034 Leading-zero blanking: load 16'h0050, blank_lz = 1 -> digits 3 and 2 slots keep an = 4'b1111 for all 4 cycles; digits 1 and 0 light.
REQ-035 All-zero value: value 16'h0000, blank_lz = 1 -> only digit 0 lights, showing 0.
REQ-036 Load mid-slot: load 16'hFFFF during cycle 2 of the idx = 1 slot -> next edge digit = F; an, cnt and slot_tick timing unchanged.
REQ-037 Wrap-around: run 64 cycles after reset.
- idx wraps 3->0 cleanly
- exactly 16 slot_tick pulses
- never more than one an bit low

Source files
------------

// File: rtl/display_scan_mux.sv
// Time-multiplexed scanner for a 4-digit common-anode 7-segment display.
// Each digit owns a CLK_DIV-cycle slot that opens with GUARD dark cycles to suppress ghosting.
module display_scan_mux #(
  parameter int CLK_DIV = 50000,
  parameter int GUARD   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        slot_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  generate
    if (CLK_DIV < 4 || CLK_DIV > (1 << 20)) begin : g_bad_div
      $error("display_scan_mux: CLK_DIV out of range");
    end
    if (GUARD < 1 || GUARD > CLK_DIV - 2) begin : g_bad_guard
      $error("display_scan_mux: GUARD out of range");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   value_q, value_d;
  logic          wrap;
  logic [3:0]    lz;       // lz[i]: nibbles i..3 of the next value are all zero
  logic          blank_d;
  logic [3:0]    digit_d;
  logic [3:0]    an_d;

  // Outputs are computed from next-state values so they line up with the state on the same edge.
  always_comb begin
    wrap    = (cnt_q == CNT_MAX);
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q + {1'b0, wrap};
    value_d = load ? value : value_q;

    lz[3] = (value_d[15:12] == 4'h0);
    lz[2] = lz[3] && (value_d[11:8] == 4'h0);
    lz[1] = lz[2] && (value_d[7:4] == 4'h0);
    lz[0] = 1'b0;

    digit_d = value_d[{idx_d, 2'b00} +: 4];
    blank_d = blank_lz && lz[idx_d];
    if ((cnt_d < GUARD_C) || blank_d) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      value_q   <= 16'h0000;
      digit     <= 4'h0;
      an        <= 4'b1111;
      slot_tick <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      value_q   <= value_d;
      digit     <= digit_d;
      an        <= an_d;
      slot_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed and randomized bench for display_scan_mux with CLK_DIV=4, GUARD=1,
// compared against a time-based reference model (edges since reset -> slot position).
module tb_display_scan_mux;

  localparam int CLK_DIV_P = 4;
  localparam int GUARD_P   = 1;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        slot_tick;

  int checks = 0;
  int errors = 0;
  int t = 0;              // rising edges since reset released
  logic [15:0] mv = '0;   // model holding register
  int tick_cnt = 0;

  display_scan_mux #(.CLK_DIV(CLK_DIV_P), .GUARD(GUARD_P)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
    .digit(digit), .an(an), .slot_tick(slot_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_digit"}, 32'(digit), 32'h0);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_tick"}, 32'(slot_tick), 32'h0);
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    int cnt, idx;
    logic bl;
    logic [15:0] upper;
    logic [3:0] nib, an_e;
    logic blank, tick_e;
    @(posedge clk);
    bl = blank_lz;
    if (!rst) begin
      if (load) mv = value;
      t++;
    end
    #1;
    cnt   = t % CLK_DIV_P;
    idx   = (t / CLK_DIV_P) % 4;
    upper = mv >> (4 * idx);
    nib   = upper[3:0];
    blank = bl && (idx > 0) && (upper == 16'h0);
    an_e  = ((cnt < GUARD_P) || blank) ? 4'hF : ~(4'(1 << idx));
    tick_e = (cnt == 0) && (t > 0);
    chk("digit", 32'(digit), 32'(nib));
    chk("an", 32'(an), 32'(an_e));
    chk("slot_tick", 32'(slot_tick), 32'(tick_e));
    chk("an_onehot", 32'($countones(~an) <= 1), 32'h1);
    if (slot_tick) tick_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; value = 16'h0; load = 1'b0; blank_lz = 1'b0;

    // power-on reset, with a load that must be ignored
    #1 chk_reset_outputs("por");
    value = 16'hBEEF; load = 1'b1;
    @(negedge clk); chk_reset_outputs("por_hold");
    @(negedge clk); chk_reset_outputs("por_hold2");
    load = 1'b0;
    rst = 1'b0; t = 0; mv = '0;

    // first edge after reset: cnt=1, idx=0, lit with GUARD=1
    step();
    chk("first_an", 32'(an), 32'hE);
    chk("first_digit", 32'(digit), 32'h0);

    // scan order
    do_load(16'h12AB);
    run(32);

    // leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0050);
    run(16);

    // all-zero value
    do_load(16'h0000);
    run(16);

    // load mid-slot (second cycle of idx=1 slot)
    blank_lz = 1'b0;
    do_load(16'h1234);
    for (int i = 0; i < 16; i++) begin
      if (t % 16 == 5) break;
      step();
    end
    do_load(16'hFFFF);
    chk("midslot_digit", 32'(digit), 32'hF);
    run(12);

    // back-to-back loads
    value = 16'h1111; load = 1'b1; step();
    value = 16'h2222; step();
    value = 16'h3333; step();
    load = 1'b0;
    run(8);

    // randomized value/load/blank_lz
    for (int i = 0; i < 300; i++) begin
      value    = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
      if ($urandom_range(0, 3) == 0) value[7:4]  = 4'h0;
      load     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) blank_lz = ~blank_lz;
      step();
    end
    load = 1'b0;

    // asynchronous reset mid-slot
    run(2);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async_rst");
    value = 16'h9876; load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_reset_outputs("rst_hold");
    end
    load = 1'b0; blank_lz = 1'b0;
    rst = 1'b0; t = 0; mv = '0;

    // 64-cycle wrap run from reset
    value = 16'hC0DE;
    load = 1'b1;
    step();
    load = 1'b0;
    tick_cnt = 0;
    run(63);
    chk("tick_count_64", 32'(tick_cnt), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
